or1k_vector_fetch_router: RTL and testbench

- Registered Wishbone B3 classic router between the CPU instruction bus master and two slaves: the procedural exception vector memory and the main memory bus.
- Reads whose address falls in the vector region go to the vector memory (13-bit address). All other accesses go to main memory.
- Adds bus-error handling: writes to the read-only vector region error, and a watchdog errors any slave that never acknowledges.

---
 rtl/or1k_vector_router_pkg.sv | 24 ++
 rtl/or1k_bus_timeout.sv | 32 +++
 rtl/or1k_vector_fetch_router.sv | 173 +++++++++++++++++
 tb/tb_or1k_vector_fetch_router.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/or1k_vector_router_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// or1k_vector_router_pkg: shared types and region constants. Revision 1.0
// ----------------------------------------------------------------------------
package or1k_vector_router_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        VEC  = 2'd1,
        MEM  = 2'd2,
        DONE = 2'd3
    } router_state_t;

    localparam logic [31:0] VECTOR_REGION_BASE_DEFAULT = 32'h0000_0000;
    localparam int          VECTOR_REGION_LOG2_DEFAULT = 13;

    function automatic logic region_hit(input logic [31:0] adr,
                                        input logic [31:0] base,
                                        input int          log2);
        return (adr >> log2) == (base >> log2);
    endfunction

endpackage
`default_nettype wire

// File: rtl/or1k_bus_timeout.sv
`default_nettype none
// ----------------------------------------------------------------------------
// or1k_bus_timeout: slave wait-state watchdog for one bus access. Revision 1.0
// ----------------------------------------------------------------------------
module or1k_bus_timeout #(
    parameter int TIMEOUT_CYCLES = 255,
    parameter int TIMEOUT_WIDTH  = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    logic [TIMEOUT_WIDTH-1:0] count;

    assign expired = (count == TIMEOUT_WIDTH'(TIMEOUT_CYCLES));

    // Holds at the limit so a late exit can never wrap back to zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired) begin
            count <= count + TIMEOUT_WIDTH'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/or1k_vector_fetch_router.sv
`default_nettype none
// ----------------------------------------------------------------------------
// or1k_vector_fetch_router: registered Wishbone router, vector memory / main memory. Revision 1.0
// ----------------------------------------------------------------------------
module or1k_vector_fetch_router
    import or1k_vector_router_pkg::*;
#(
    parameter logic [31:0] VECTOR_REGION_BASE = VECTOR_REGION_BASE_DEFAULT,
    parameter int          VECTOR_REGION_LOG2 = VECTOR_REGION_LOG2_DEFAULT,
    parameter int          TIMEOUT_CYCLES     = 255,
    parameter int          TIMEOUT_WIDTH      = 8
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] m_adr_i,
    input  logic        m_cyc_i,
    input  logic        m_stb_i,
    input  logic        m_we_i,
    output logic [31:0] m_dat_o,
    output logic        m_ack_o,
    output logic        m_err_o,
    output logic [12:0] vec_adr_o,
    output logic        vec_cyc_o,
    output logic        vec_stb_o,
    input  logic [31:0] vec_dat_i,
    input  logic        vec_ack_i,
    output logic [31:0] mem_adr_o,
    output logic        mem_cyc_o,
    output logic        mem_stb_o,
    output logic        mem_we_o,
    input  logic [31:0] mem_dat_i,
    input  logic        mem_ack_i,
    input  logic        mem_err_i,
    output logic [31:0] err_adr_o
);

    router_state_t state, state_nxt;
    logic [31:0]   adr_q, adr_nxt;
    logic          we_q, we_nxt;
    logic          wr_fault, wr_fault_nxt;
    logic          vec_cyc_nxt, mem_cyc_nxt, mem_we_nxt;
    logic          ack_nxt, err_nxt;
    logic [31:0]   dat_nxt, err_adr_nxt;
    logic          busy, expired;

    assign busy      = (state == VEC) || (state == MEM);
    assign vec_stb_o = vec_cyc_o;
    assign mem_stb_o = mem_cyc_o;
    assign vec_adr_o = adr_q[12:0];
    assign mem_adr_o = adr_q;

    or1k_bus_timeout #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .TIMEOUT_WIDTH  (TIMEOUT_WIDTH)
    ) u_timeout (
        .clk     (clk_i),
        .rst_n   (rst_i),
        .clear   (!busy),
        .enable  (busy),
        .expired (expired)
    );

    always_comb begin
        state_nxt    = state;
        adr_nxt      = adr_q;
        we_nxt       = we_q;
        wr_fault_nxt = wr_fault;
        vec_cyc_nxt  = 1'b0;
        mem_cyc_nxt  = 1'b0;
        mem_we_nxt   = 1'b0;
        ack_nxt      = 1'b0;
        err_nxt      = 1'b0;
        dat_nxt      = m_dat_o;
        err_adr_nxt  = err_adr_o;

        case (state)
            IDLE: begin
                if (m_cyc_i && m_stb_i) begin
                    adr_nxt = m_adr_i;
                    we_nxt  = m_we_i;
                    if (region_hit(m_adr_i, VECTOR_REGION_BASE, VECTOR_REGION_LOG2)) begin
                        // Writes to the read-only region are answered by an internal
                        // zero-wait error responder, so they keep the 3-cycle cadence.
                        state_nxt    = VEC;
                        wr_fault_nxt = m_we_i;
                        vec_cyc_nxt  = !m_we_i;
                    end else begin
                        state_nxt    = MEM;
                        wr_fault_nxt = 1'b0;
                        mem_cyc_nxt  = 1'b1;
                        mem_we_nxt   = m_we_i;
                    end
                end
            end
            VEC: begin
                vec_cyc_nxt = !wr_fault;
                if (!m_cyc_i) begin
                    state_nxt   = IDLE;
                    vec_cyc_nxt = 1'b0;
                end else if (wr_fault || (vec_ack_i ? 1'b0 : expired)) begin
                    state_nxt   = DONE;
                    vec_cyc_nxt = 1'b0;
                    err_nxt     = 1'b1;
                    dat_nxt     = '0;
                    err_adr_nxt = adr_q;
                end else if (vec_ack_i) begin
                    state_nxt   = DONE;
                    vec_cyc_nxt = 1'b0;
                    ack_nxt     = 1'b1;
                    dat_nxt     = vec_dat_i;
                end
            end
            MEM: begin
                mem_cyc_nxt = 1'b1;
                mem_we_nxt  = we_q;
                if (!m_cyc_i) begin
                    state_nxt   = IDLE;
                    mem_cyc_nxt = 1'b0;
                    mem_we_nxt  = 1'b0;
                end else if (mem_err_i || (!mem_ack_i && expired)) begin
                    state_nxt   = DONE;
                    mem_cyc_nxt = 1'b0;
                    mem_we_nxt  = 1'b0;
                    err_nxt     = 1'b1;
                    dat_nxt     = '0;
                    err_adr_nxt = adr_q;
                end else if (mem_ack_i) begin
                    state_nxt   = DONE;
                    mem_cyc_nxt = 1'b0;
                    mem_we_nxt  = 1'b0;
                    ack_nxt     = 1'b1;
                    dat_nxt     = mem_dat_i;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state     <= IDLE;
            adr_q     <= '0;
            we_q      <= 1'b0;
            wr_fault  <= 1'b0;
            vec_cyc_o <= 1'b0;
            mem_cyc_o <= 1'b0;
            mem_we_o  <= 1'b0;
            m_ack_o   <= 1'b0;
            m_err_o   <= 1'b0;
            m_dat_o   <= '0;
            err_adr_o <= '0;
        end else begin
            state     <= state_nxt;
            adr_q     <= adr_nxt;
            we_q      <= we_nxt;
            wr_fault  <= wr_fault_nxt;
            vec_cyc_o <= vec_cyc_nxt;
            mem_cyc_o <= mem_cyc_nxt;
            mem_we_o  <= mem_we_nxt;
            m_ack_o   <= ack_nxt;
            m_err_o   <= err_nxt;
            m_dat_o   <= dat_nxt;
            err_adr_o <= err_adr_nxt;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_or1k_vector_fetch_router.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_or1k_vector_fetch_router: scoreboard bench for the vector fetch router. Revision 1.0
// ----------------------------------------------------------------------------
module tb_or1k_vector_fetch_router;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic [31:0] m_adr_i = '0;
    logic        m_cyc_i = 1'b0;
    logic        m_stb_i = 1'b0;
    logic        m_we_i = 1'b0;
    logic [31:0] m_dat_o;
    logic        m_ack_o, m_err_o;
    logic [12:0] vec_adr_o;
    logic        vec_cyc_o, vec_stb_o;
    logic [31:0] vec_dat_i = '0;
    logic        vec_ack_i;
    logic [31:0] mem_adr_o;
    logic        mem_cyc_o, mem_stb_o, mem_we_o;
    logic [31:0] mem_dat_i = '0;
    logic        mem_ack_i, mem_err_i;
    logic [31:0] err_adr_o;

    int applied = 0;
    int fails   = 0;
    int cyc     = 0;

    // Main-memory slave: mode 0 ack, 1 err, 2 never responds, 3 ack and err together.
    int mem_mode = 0;
    int mem_wait = 0;
    int mem_cnt  = 0;

    typedef struct {
        bit          err;
        logic [31:0] dat;
        logic [31:0] eadr;
        int          cyc;
    } exp_t;
    exp_t q[$];

    or1k_vector_fetch_router #(
        .TIMEOUT_CYCLES (4),
        .TIMEOUT_WIDTH  (8)
    ) dut (
        .clk_i     (clk),
        .rst_i     (rst_i),
        .m_adr_i   (m_adr_i),
        .m_cyc_i   (m_cyc_i),
        .m_stb_i   (m_stb_i),
        .m_we_i    (m_we_i),
        .m_dat_o   (m_dat_o),
        .m_ack_o   (m_ack_o),
        .m_err_o   (m_err_o),
        .vec_adr_o (vec_adr_o),
        .vec_cyc_o (vec_cyc_o),
        .vec_stb_o (vec_stb_o),
        .vec_dat_i (vec_dat_i),
        .vec_ack_i (vec_ack_i),
        .mem_adr_o (mem_adr_o),
        .mem_cyc_o (mem_cyc_o),
        .mem_stb_o (mem_stb_o),
        .mem_we_o  (mem_we_o),
        .mem_dat_i (mem_dat_i),
        .mem_ack_i (mem_ack_i),
        .mem_err_i (mem_err_i),
        .err_adr_o (err_adr_o)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    assign vec_ack_i = vec_cyc_o & vec_stb_o;
    always @(posedge clk) mem_cnt <= mem_stb_o ? mem_cnt + 1 : 0;
    assign mem_ack_i = mem_stb_o && (mem_cnt == mem_wait) && (mem_mode == 0 || mem_mode == 3);
    assign mem_err_i = mem_stb_o && (mem_cnt == mem_wait) && (mem_mode == 1 || mem_mode == 3);

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        applied++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // Monitor: every response the DUT presents is matched against the queue head.
    always @(negedge clk) begin
        if (rst_i && (m_ack_o || m_err_o)) begin
            if (q.size() == 0) begin
                check("unexpected_response", {30'd0, m_ack_o, m_err_o}, 32'd0);
            end else begin
                exp_t e;
                e = q.pop_front();
                check("resp_ack", {31'd0, m_ack_o}, {31'd0, !e.err});
                check("resp_err", {31'd0, m_err_o}, {31'd0, e.err});
                check("resp_dat", m_dat_o, e.dat);
                check("resp_cycle", cyc, e.cyc);
                if (e.err) check("resp_err_adr", err_adr_o, e.eadr);
            end
        end
    end

    task automatic start_req(input logic [31:0] adr, input bit we, input bit push,
                             input bit err, input logic [31:0] dat, input int lat);
        @(negedge clk);
        m_adr_i = adr;
        m_we_i  = we;
        m_cyc_i = 1'b1;
        m_stb_i = 1'b1;
        if (push) q.push_back('{err: err, dat: dat, eadr: adr, cyc: cyc + lat});
    endtask

    task automatic wait_resp(input int budget, output int vec_hi, output int mem_hi);
        bit got;
        got = 1'b0;
        vec_hi = 0;
        mem_hi = 0;
        for (int i = 0; i < budget && !got; i++) begin
            @(negedge clk);
            if (vec_cyc_o) vec_hi++;
            if (mem_stb_o) mem_hi++;
            if (m_ack_o || m_err_o) got = 1'b1;
        end
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
        m_we_i  = 1'b0;
        check("response_within_budget", {31'd0, got}, 32'd1);
        @(negedge clk);
        check("slaves_idle_after", {30'd0, vec_cyc_o, mem_cyc_o}, 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int vh, mh, seen;

        repeat (3) @(negedge clk);
        check("reset_ack_err", {30'd0, m_ack_o, m_err_o}, 32'd0);
        check("reset_dat", m_dat_o, 32'd0);
        check("reset_err_adr", err_adr_o, 32'd0);
        check("reset_cyc", {28'd0, vec_cyc_o, vec_stb_o, mem_cyc_o, mem_stb_o}, 32'd0);
        check("reset_adr", mem_adr_o | {19'd0, vec_adr_o}, 32'd0);
        rst_i = 1'b1;
        repeat (2) @(negedge clk);

        // Vector read, combinational ack.
        vec_dat_i = 32'h0000_07C2;
        start_req(32'h0000_0100, 1'b0, 1'b1, 1'b0, 32'h0000_07C2, 2);
        @(negedge clk);
        check("vec_read_cyc", {31'd0, vec_cyc_o}, 32'd1);
        check("vec_read_adr", {19'd0, vec_adr_o}, 32'h0000_0100);
        wait_resp(10, vh, mh);
        check("vec_read_mem_idle", mh, 0);

        // Main memory read with 3 wait states.
        mem_mode = 0; mem_wait = 3; mem_dat_i = 32'hDEAD_BEEF;
        start_req(32'h0000_2008, 1'b0, 1'b1, 1'b0, 32'hDEAD_BEEF, 5);
        @(negedge clk);
        check("mem_read_adr", mem_adr_o, 32'h0000_2008);
        check("mem_read_we", {31'd0, mem_we_o}, 32'd0);
        wait_resp(12, vh, mh);
        check("mem_read_vec_idle", vh, 0);

        // Master abort in the second MEM cycle.
        mem_mode = 2;
        start_req(32'h0000_3000, 1'b0, 1'b0, 1'b0, 32'd0, 0);
        seen = 0;
        repeat (2) begin
            @(negedge clk);
            if (m_ack_o || m_err_o) seen++;
        end
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
        @(negedge clk);
        check("abort_mem_cyc_low", {31'd0, mem_cyc_o}, 32'd0);
        repeat (8) begin
            @(negedge clk);
            if (m_ack_o || m_err_o) seen++;
        end
        check("abort_no_response", seen, 0);
        check("abort_dat_kept", m_dat_o, 32'hDEAD_BEEF);
        start_req(32'h0000_0100, 1'b0, 1'b1, 1'b0, 32'h0000_07C2, 2);
        wait_resp(10, vh, mh);

        // Write into the read-only vector region.
        start_req(32'h0000_0200, 1'b1, 1'b1, 1'b1, 32'd0, 2);
        wait_resp(10, vh, mh);
        check("vec_write_no_strobe", vh + mh, 0);
        check("vec_write_err_adr", err_adr_o, 32'h0000_0200);

        // Timeout on a slave that never acknowledges.
        mem_mode = 2;
        start_req(32'h0010_0000, 1'b0, 1'b1, 1'b1, 32'd0, 6);
        wait_resp(12, vh, mh);
        check("timeout_stb_cycles", mh, 5);
        check("timeout_err_adr", err_adr_o, 32'h0010_0000);

        // Simultaneous ack and err from main memory: err wins.
        mem_mode = 3; mem_wait = 1; mem_dat_i = 32'h1234_5678;
        start_req(32'h0000_4000, 1'b0, 1'b1, 1'b1, 32'd0, 3);
        wait_resp(10, vh, mh);

        // Wrapped top-of-space address routes to main memory.
        mem_mode = 0; mem_wait = 0; mem_dat_i = 32'hCAFE_F00D;
        start_req(32'hFFFF_FFFC, 1'b0, 1'b1, 1'b0, 32'hCAFE_F00D, 2);
        wait_resp(10, vh, mh);
        check("wrap_routes_mem", {vh[15:0], mh[15:0]}, 32'h0000_0001);

        // Reset asserted mid-access clears outputs without a clock edge.
        mem_mode = 2;
        start_req(32'h0000_5000, 1'b0, 1'b0, 1'b0, 32'd0, 0);
        @(negedge clk);
        check("rst_mid_mem_active", {31'd0, mem_cyc_o}, 32'd1);
        #2 rst_i = 1'b0;
        #1;
        check("rst_async_cyc", {28'd0, vec_cyc_o, vec_stb_o, mem_cyc_o, mem_stb_o}, 32'd0);
        check("rst_async_adr", mem_adr_o, 32'd0);
        check("rst_async_err_adr", err_adr_o, 32'd0);
        check("rst_async_dat", m_dat_o, 32'd0);
        m_cyc_i = 1'b0;
        m_stb_i = 1'b0;
        repeat (2) @(negedge clk);
        rst_i = 1'b1;
        start_req(32'h0000_0100, 1'b0, 1'b1, 1'b0, 32'h0000_07C2, 2);
        wait_resp(10, vh, mh);

        repeat (3) @(negedge clk);
        check("scoreboard_drained", q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", applied, fails);
        $finish;
    end

endmodule
`default_nettype wire
